fifo: RTL and testbench

Synchronous single-clock first-in/first-out buffer with registered read data and four status flags. It decouples a producer and a consumer sharing one clock domain, absorbing bursts of up to `DEPTH` words. It is used as a generic datapath buffer between pipeline stages.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 47 ++++
 rtl/fifo.sv | 83 ++++++++
 tb/tb_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared defaults and width helper for the single-clock FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem
//  Purpose  : DEPTH x WIDTH register array, synchronous write, registered read.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking semantics return pre-edge contents when read and write
    // hit the same slot (full FIFO with simultaneous read and write).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fifo
//  Purpose  : Single-clock FIFO with registered read data and status flags.
//  Revision : 1.0  initial release
// ============================================================================
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             fifo_not_empty,
    output logic             fifo_not_full
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // A read frees a slot in the same edge, so a full FIFO still takes a write.
    assign w_wr_acc = write && (!w_full || read);
    assign w_rd_acc = read && !w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr),
        .rd_data (data_out)
    );

    assign fifo_full      = w_full;
    assign fifo_empty     = w_empty;
    assign fifo_not_full  = ~w_full;
    assign fifo_not_empty = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo
//  Purpose  : Self-checking bench for fifo against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_not_empty;
    logic             fifo_not_full;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] model_dout;

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .write          (write),
        .read           (read),
        .data_out       (data_out),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_not_empty (fifo_not_empty),
        .fifo_not_full  (fifo_not_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".data_out"},  32'(data_out),       32'(model_dout));
        check({tag, ".empty"},     32'(fifo_empty),     32'(sz == 0));
        check({tag, ".full"},      32'(fifo_full),      32'(sz == DEPTH));
        check({tag, ".not_empty"}, 32'(fifo_not_empty), 32'(sz != 0));
        check({tag, ".not_full"},  32'(fifo_not_full),  32'(sz != DEPTH));
    endtask

    // Apply one edge: model decides acceptance from pre-edge occupancy.
    task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] din, input string tag);
        bit was_full, was_empty;
        write   = wr;
        read    = rd;
        data_in = din;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        @(posedge clk);
        if (rd && !was_empty) model_dout = model_q.pop_front();
        if (wr && (!was_full || rd)) model_q.push_back(din);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        model_q.delete();
        model_dout = '0;
        #1;
        check_all(tag);
        write = 1'b0;
        read  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int wr_pct;
        int rd_pct;
        rst        = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        data_in    = '0;
        model_dout = '0;

        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Fill, then an ignored write while full
        step(1, 0, 16'd3,  "fill0");
        step(1, 0, 16'd10, "fill1");
        step(1, 0, 16'd15, "fill2");
        step(1, 0, 16'd18, "fill3");
        step(1, 0, 16'd99, "fill_over");

        // Drain past empty; data_out holds the last word
        for (int i = 0; i < 6; i++) step(0, 1, 16'd0, "drain");
        check("drain_hold", 32'(data_out), 32'd18);

        // Full plus simultaneous read/write
        step(1, 0, 16'd3,  "refill0");
        step(1, 0, 16'd10, "refill1");
        step(1, 0, 16'd15, "refill2");
        step(1, 0, 16'd18, "refill3");
        step(1, 1, 16'd21, "full_rw");
        check("full_rw_out", 32'(data_out), 32'd3);
        step(0, 1, 16'd0, "post_full_rw0");
        check("post_full_rw0_val", 32'(data_out), 32'd10);
        step(0, 1, 16'd0, "post_full_rw1");
        step(0, 1, 16'd0, "post_full_rw2");
        step(0, 1, 16'd0, "post_full_rw3");
        check("post_full_rw3_val", 32'(data_out), 32'd21);

        // Empty plus simultaneous read/write: no bypass
        step(1, 1, 16'd7, "empty_rw");
        check("empty_rw_hold", 32'(data_out), 32'd21);
        step(0, 1, 16'd0, "empty_rw_read");
        check("empty_rw_read_val", 32'(data_out), 32'd7);

        // Streaming across pointer wrap
        step(1, 0, 16'd100, "stream_prime");
        for (int i = 1; i <= 12; i++) step(1, 1, WIDTH'(100 + i), "stream");
        step(0, 1, 16'd0, "stream_tail");
        check("stream_last", 32'(data_out), 32'd112);

        // Asynchronous reset mid-operation
        step(1, 0, 16'd55, "pre_rst0");
        step(1, 0, 16'd56, "pre_rst1");
        async_reset("async_rst");

        // Randomised phases biasing toward fill, drain and balance
        for (int ph = 0; ph < 6; ph++) begin
            case (ph % 3)
                0: begin wr_pct = 80; rd_pct = 25; end
                1: begin wr_pct = 25; rd_pct = 80; end
                default: begin wr_pct = 60; rd_pct = 60; end
            endcase
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
                     WIDTH'($urandom), "rand");
            end
        end

        async_reset("final_rst");
        step(0, 0, 16'd0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
